capture_cmp_unit: RTL

- Downstream checker for the launch-flop / buffer-chain / broadcast-capture structure.
- Takes the bit captured at the end of the long buffered path (long_d) and the NUM_SHORT bits captured directly from the launch net (short_d).
- Aligns them in time and flags any cycle where the captures disagree.
- Counts mismatches, raises sticky flags, and exports mismatch snapshots through a valid/ready port. Sits beside the capture flops as a timing-closure sanity monitor.

---
 rtl/capture_cmp_pkg.sv | 25 ++
 rtl/capture_cmp_unit_fifo.sv | 77 +++++++
 rtl/capture_cmp_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/capture_cmp_pkg.sv
`default_nettype none
// ============================================================================
// capture_cmp_pkg : shared types and helpers for the capture compare monitor
// Rev 1.0
// ============================================================================
package capture_cmp_pkg;

  localparam int ALIGN_MAX = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // Increment that sticks at the all-ones value of a counter 'width' bits wide.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_v;
    max_v = (32'd1 << width) - 32'd1;
    return (val >= max_v) ? max_v : val + 32'd1;
  endfunction

endpackage : capture_cmp_pkg
`default_nettype wire

// File: rtl/capture_cmp_unit_fifo.sv
`default_nettype none
// ============================================================================
// snap_fifo2 : 2-entry FIFO with registered valid/data outputs and flush
// Rev 1.0
// ============================================================================
module snap_fifo2 #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             drop_o
);

  logic             vld0_q, vld0_d;
  logic             vld1_q, vld1_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             pop;

  assign pop     = vld0_q & ready_i;
  assign valid_o = vld0_q;
  assign data_o  = head_q;
  // A push is lost only when both slots are busy and nothing leaves this cycle.
  assign drop_o  = push_i & vld1_q & ~pop & ~flush_i;

  always_comb begin
    vld0_d = vld0_q;
    vld1_d = vld1_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush_i) begin
      vld0_d = 1'b0;
      vld1_d = 1'b0;
      head_d = '0;
      tail_d = '0;
    end else if (pop) begin
      if (vld1_q) begin
        head_d = tail_q;
        if (push_i) tail_d = data_i;
        else        vld1_d = 1'b0;
      end else begin
        if (push_i) head_d = data_i;
        else        vld0_d = 1'b0;
      end
    end else if (push_i) begin
      if (!vld0_q) begin
        head_d = data_i;
        vld0_d = 1'b1;
      end else if (!vld1_q) begin
        tail_d = data_i;
        vld1_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld0_q <= 1'b0;
      vld1_q <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      vld0_q <= vld0_d;
      vld1_q <= vld1_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule : snap_fifo2
`default_nettype wire

// File: rtl/capture_cmp_unit.sv
`default_nettype none
// ============================================================================
// capture_cmp_unit : aligns long-path and direct captures, counts mismatches
// Rev 1.0
// ============================================================================
module capture_cmp_unit
  import capture_cmp_pkg::*;
#(
  parameter int NUM_SHORT   = 10,
  parameter int ALIGN       = 1,
  parameter int CNT_W       = 8,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 long_d,
  input  logic [NUM_SHORT-1:0] short_d,
  output logic                 snap_valid,
  input  logic                 snap_ready,
  output logic [NUM_SHORT:0]   snap_data,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 err_sticky,
  output logic                 ovf_sticky,
  output logic [1:0]           state_o
);

  localparam logic [2:0] ALIGN_LAST = 3'(ALIGN);

  logic                 long_q;
  logic [NUM_SHORT-1:0] short_q;
  logic [NUM_SHORT-1:0] short_al;
  state_e               state_q, state_d;
  logic [2:0]           warm_q, warm_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 ovf_q, ovf_d;
  logic                 mismatch;
  logic                 count_en;
  logic                 fifo_drop;

  if (ALIGN > ALIGN_MAX) begin : g_bad_align
    $error("capture_cmp_unit: ALIGN out of range");
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      long_q  <= 1'b0;
      short_q <= '0;
    end else begin
      long_q  <= long_d;
      short_q <= short_d;
    end
  end

  if (ALIGN == 0) begin : g_no_align
    assign short_al = short_q;
  end else begin : g_align
    logic [NUM_SHORT-1:0] pipe_q [ALIGN];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < ALIGN; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= short_q;
        for (int i = 1; i < ALIGN; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign short_al = pipe_q[ALIGN-1];
  end

  assign mismatch = |(short_al ^ {NUM_SHORT{long_q}});

  // ARM stays for ALIGN+1 cycles so stale pipeline contents never get counted.
  always_comb begin
    state_d  = state_q;
    warm_d   = 3'd0;
    count_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!en)                       state_d = ST_IDLE;
        else if (warm_q == ALIGN_LAST) state_d = ST_RUN;
        else                           warm_d  = warm_q + 3'd1;
      end
      ST_RUN: begin
        count_en = mismatch;
        if (!en)                          state_d = ST_IDLE;
        else if (mismatch && STOP_ON_ERR) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        state_d = ST_HOLD;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr) begin
      state_d  = ST_IDLE;
      warm_d   = 3'd0;
      count_en = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      err_d = 1'b0;
      ovf_d = 1'b0;
    end else begin
      if (count_en) begin
        cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
        err_d = 1'b1;
      end
      if (fifo_drop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      warm_q  <= 3'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  snap_fifo2 #(
    .WIDTH(NUM_SHORT + 1)
  ) u_snap_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (clr),
    .push_i  (count_en),
    .data_i  ({long_q, short_al}),
    .ready_i (snap_ready),
    .valid_o (snap_valid),
    .data_o  (snap_data),
    .drop_o  (fifo_drop)
  );

  assign err_cnt    = cnt_q;
  assign err_sticky = err_q;
  assign ovf_sticky = ovf_q;
  assign state_o    = state_q;

endmodule : capture_cmp_unit
`default_nettype wire
